// File: rtl/piso_loader_pkg.sv
// Shared definitions for the parallel-in / serial-out loader: state encoding
// and a width helper for its counters.
package piso_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   localparam int GAP_CNT_W = 4;

   // Bits needed to count 0..value-1, never less than one.
   function automatic int clog2(input int value);
      int width;
      width = 1;
      for (int i = 1; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            width = i + 1;
         end else begin
            width = width;
         end
      end
      return width;
   endfunction

endpackage

// File: rtl/piso_loader_mod_counter.sv
// Up-counter with synchronous clear, load-to-zero and terminal-count flag.
// It stops at MOD-1 and only leaves that value through an explicit reload.
module mod_counter #(
   parameter int MOD = 8,
   parameter int W   = 3
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         load_zero,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         tc
);

   localparam logic [W-1:0] TC_VAL = W'(MOD - 1);

   logic [W-1:0] cnt_r;

   // Count register: clear has priority, then reload, then saturating increment.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         cnt_r <= '0;
      end else if (load_zero) begin
         cnt_r <= '0;
      end else if (en && (cnt_r != TC_VAL)) begin
         cnt_r <= cnt_r + W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cnt = cnt_r;
   assign tc  = (cnt_r == TC_VAL);

endmodule

// File: rtl/piso_loader.sv
// Serializes N-bit words accepted over valid/ready into a one-bit stream with
// a per-bit qualifier, a last-bit flag and an optional idle gap between words.
module piso_loader
   import piso_pkg::*;
#(
   parameter int N         = 8,
   parameter int LSB_FIRST = 0,
   parameter int GAP       = 0
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic [N-1:0] din,
   input  logic         din_valid,
   output logic         din_ready,
   output logic         sout,
   output logic         sout_valid,
   output logic         last,
   output logic         busy
);

   localparam int CW = clog2(N);
   localparam logic [CW-1:0] BEFORE_LAST = CW'(N - 2);

   state_t         state_r, state_s;
   logic [N-1:0]   hold_r, hold_s;
   logic           sout_r, sout_s;
   logic           sout_valid_r, sout_valid_s;
   logic           last_r, last_s;
   logic           busy_r;
   logic           ready_s;
   logic           bit_load_s, bit_en_s, bit_tc_s;
   logic [CW-1:0]  bit_cnt_s;
   logic           gap_load_s, gap_en_s, gap_tc_s;

   function automatic logic head_bit(input logic [N-1:0] v);
      if (LSB_FIRST != 0) begin
         return v[0];
      end else begin
         return v[N-1];
      end
   endfunction

   // The holding register always keeps the next bit to send at the output end.
   function automatic logic [N-1:0] shift_word(input logic [N-1:0] v);
      if (LSB_FIRST != 0) begin
         return {1'b0, v[N-1:1]};
      end else begin
         return {v[N-2:0], 1'b0};
      end
   endfunction

   mod_counter #(.MOD(N), .W(CW)) u_bit_cnt (
      .clk       (clk),
      .clr_n     (clr_n),
      .load_zero (bit_load_s),
      .en        (bit_en_s),
      .cnt       (bit_cnt_s),
      .tc        (bit_tc_s)
   );

   generate
      if (GAP > 0) begin : g_gap
         logic [GAP_CNT_W-1:0] unused_gap_cnt_s;
         mod_counter #(.MOD(GAP), .W(GAP_CNT_W)) u_gap_cnt (
            .clk       (clk),
            .clr_n     (clr_n),
            .load_zero (gap_load_s),
            .en        (gap_en_s),
            .cnt       (unused_gap_cnt_s),
            .tc        (gap_tc_s)
         );
      end else begin : g_no_gap
         logic unused_gap_s;
         assign unused_gap_s = gap_load_s ^ gap_en_s;
         assign gap_tc_s     = 1'b1;
      end
   endgenerate

   // Next-state, next-output and counter control.
   always_comb begin
      state_s      = state_r;
      hold_s       = hold_r;
      sout_s       = 1'b0;
      sout_valid_s = 1'b0;
      last_s       = 1'b0;
      ready_s      = 1'b0;
      bit_load_s   = 1'b0;
      bit_en_s     = 1'b0;
      gap_load_s   = 1'b0;
      gap_en_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            ready_s = 1'b1;
            if (din_valid) begin
               state_s      = ST_SHIFT;
               hold_s       = shift_word(din);
               sout_s       = head_bit(din);
               sout_valid_s = 1'b1;
               bit_load_s   = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            ready_s = (GAP == 0) && bit_tc_s;
            if (!bit_tc_s) begin
               hold_s       = shift_word(hold_r);
               sout_s       = head_bit(hold_r);
               sout_valid_s = 1'b1;
               last_s       = (bit_cnt_s == BEFORE_LAST);
               bit_en_s     = 1'b1;
            end else if (ready_s && din_valid) begin
               // Back-to-back reload keeps the stream free of bubbles.
               state_s      = ST_SHIFT;
               hold_s       = shift_word(din);
               sout_s       = head_bit(din);
               sout_valid_s = 1'b1;
               bit_load_s   = 1'b1;
            end else if (GAP > 0) begin
               state_s    = ST_GAP;
               gap_load_s = 1'b1;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (gap_tc_s) begin
               state_s = ST_IDLE;
            end else begin
               gap_en_s = 1'b1;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, holding register and registered outputs.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state_r      <= ST_IDLE;
         hold_r       <= '0;
         sout_r       <= 1'b0;
         sout_valid_r <= 1'b0;
         last_r       <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         hold_r       <= hold_s;
         sout_r       <= sout_s;
         sout_valid_r <= sout_valid_s;
         last_r       <= last_s;
         busy_r       <= (state_s != ST_IDLE);
      end
   end

   assign din_ready  = ready_s;
   assign sout       = sout_r;
   assign sout_valid = sout_valid_r;
   assign last       = last_r;
   assign busy       = busy_r;

endmodule
